// File: rtl/t5_dwbm.sv
// t5_dwbm -- Wishbone classic data-bus master for a RISC-V load/store stage.
//
// Ports:
//   sclk, srst         clock, synchronous active-high reset
//   sena               pipeline advance enable (low = stall)
//   xreq/xwre/xopc     execute-stage request, store flag, RV funct3 size code
//   xadr/xdat          effective byte address, right-aligned store data
//   xstb               {dwb_stb, dwb_wre} status to the system controller
//   dwb_*              Wishbone classic master signals
//   mdat               registered, aligned and extended load result
//   mmis               one-cycle pulse: misaligned or illegal access rejected
//   merr               one-cycle pulse: bus watchdog timeout
module t5_dwbm #(
   parameter int unsigned XLEN = 32
) (
   input  logic            sclk,
   input  logic            srst,
   input  logic            sena,
   input  logic            xreq,
   input  logic            xwre,
   input  logic [2:0]      xopc,
   input  logic [XLEN-1:0] xadr,
   input  logic [XLEN-1:0] xdat,
   output logic [1:0]      xstb,
   output logic            dwb_cyc,
   output logic            dwb_stb,
   output logic            dwb_wre,
   output logic [XLEN-1:0] dwb_adr,
   output logic [3:0]      dwb_sel,
   output logic [XLEN-1:0] dwb_dto,
   input  logic [XLEN-1:0] dwb_dti,
   input  logic            dwb_ack,
   output logic [XLEN-1:0] mdat,
   output logic            mmis,
   output logic            merr
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t          state, state_nxt;
   logic [7:0]      wdog;
   logic [2:0]      opc_q;
   logic [1:0]      off_q;
   logic            wre_q;
   logic            legal, busy, done, timeout, open, take, reject;
   logic [3:0]      sel_nxt;
   logic [XLEN-1:0] dto_nxt, lane, load_val;

   always_comb begin
      legal = 1'b0;
      case (xopc)
         3'b000, 3'b100: legal = 1'b1;
         3'b001, 3'b101: legal = ~xadr[0];
         3'b010:         legal = (xadr[1:0] == 2'b00);
         default:        legal = 1'b0;
      endcase
   end

   assign busy    = (state == BUSY);
   assign done    = busy & dwb_ack;
   // The count reaches 255 on the edge closing the 255th unacknowledged
   // BUSY cycle, so the strobe is up for at most 255 cycles.
   assign timeout = busy & ~dwb_ack & (wdog == 8'd254);
   // A new request is only considered when no transfer is outstanding
   // after this edge; this also blocks capture on a timeout edge.
   assign open    = ~busy | done;
   assign take    = open & sena & xreq & legal;
   assign reject  = open & sena & xreq & ~legal;

   always_ff @(posedge sclk) begin
      if (srst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (take) state_nxt = BUSY;
         BUSY: begin
            if (done)         state_nxt = take ? BUSY : IDLE;
            else if (timeout) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Lane select and lane-replicated write data for the incoming request.
   always_comb begin
      sel_nxt = 4'b1111;
      dto_nxt = xdat;
      case (xopc[1:0])
         2'b00: begin
            sel_nxt = 4'b0001 << xadr[1:0];
            dto_nxt = {4{xdat[7:0]}};
         end
         2'b01: begin
            sel_nxt = xadr[1] ? 4'b1100 : 4'b0011;
            dto_nxt = {2{xdat[15:0]}};
         end
         default: begin
            sel_nxt = 4'b1111;
            dto_nxt = xdat;
         end
      endcase
   end

   assign lane = dwb_dti >> {off_q, 3'b000};

   always_comb begin
      load_val = dwb_dti;
      case (opc_q)
         3'b000:  load_val = {{(XLEN-8){lane[7]}}, lane[7:0]};
         3'b100:  load_val = {{(XLEN-8){1'b0}}, lane[7:0]};
         3'b001:  load_val = {{(XLEN-16){lane[15]}}, lane[15:0]};
         3'b101:  load_val = {{(XLEN-16){1'b0}}, lane[15:0]};
         default: load_val = dwb_dti;
      endcase
   end

   always_ff @(posedge sclk) begin
      if (srst) begin
         dwb_adr <= '0;
         dwb_sel <= '0;
         dwb_dto <= '0;
         wre_q   <= 1'b0;
         opc_q   <= '0;
         off_q   <= '0;
         wdog    <= '0;
         mdat    <= '0;
         mmis    <= 1'b0;
         merr    <= 1'b0;
      end else begin
         mmis <= reject;
         merr <= timeout;
         if (take) begin
            dwb_adr <= {xadr[XLEN-1:2], 2'b00};
            dwb_sel <= sel_nxt;
            dwb_dto <= dto_nxt;
            wre_q   <= xwre;
            opc_q   <= xopc;
            off_q   <= xadr[1:0];
            wdog    <= '0;
         end else if (busy && !dwb_ack) begin
            wdog <= timeout ? 8'd0 : wdog + 8'd1;
         end
         if (done && !wre_q) mdat <= load_val;
      end
   end

   assign dwb_stb = busy;
   assign dwb_cyc = busy;
   assign dwb_wre = busy & wre_q;
   assign xstb    = {dwb_stb, dwb_wre};

endmodule
